feature_upsample: RTL

- Nearest-neighbour upsampler/replay generator: the producer side of the framed feature stream that the max-pool stage consumes.
- Accepts one group of NO_FEATURE_PLANES_SER serial words per pooled pixel.
- Re-emits that group POOL_SIZE times, generating the feature_valid/feature_first/feature_last framing.
- Sits in decoder/unpool paths, and in self-checking loopbacks feeding maxpool directly.

---
 rtl/cnn_stream_pkg.sv | 20 ++
 rtl/feature_pingpong_buf.sv | 99 +++++++++
 rtl/feature_upsample.sv | 131 +++++++++++++
 3 files changed

// File: rtl/cnn_stream_pkg.sv
// Shared types and defaults for the framed feature stream (upsampler and maxpool).
package cnn_stream_pkg;

  localparam int FEATURE_WIDTH_DEF         = 8;
  localparam int NO_FEATURE_PLANES_PAR_DEF = 3;
  localparam int NO_FEATURE_PLANES_SER_DEF = 3;
  localparam int POOL_SIZE_DEF             = 4;

  typedef enum logic [1:0] {
    BANK_EMPTY     = 2'd0,
    BANK_FILLING   = 2'd1,
    BANK_FULL      = 2'd2,
    BANK_REPLAYING = 2'd3
  } bank_state_t;

  function automatic int stream_width(input int feature_width, input int planes_par);
    return feature_width * planes_par;
  endfunction

endpackage

// File: rtl/feature_pingpong_buf.sv
// Two-bank ping-pong store of serial word groups with per-bank lifecycle state.
module feature_pingpong_buf
  import cnn_stream_pkg::*;
#(
  parameter int STREAM_WIDTH          = 24,
  parameter int NO_FEATURE_PLANES_SER = 3,
  localparam int SER_W                = $clog2(NO_FEATURE_PLANES_SER)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_en_i,
  input  logic                    wr_restart_i,
  input  logic [STREAM_WIDTH-1:0] wr_data_i,
  output logic                    wr_ready_o,
  output logic [SER_W-1:0]        wr_idx_o,
  input  logic                    rd_start_i,
  input  logic                    rd_release_i,
  input  logic [SER_W-1:0]        rd_ser_i,
  output logic [STREAM_WIDTH-1:0] rd_data_o,
  output logic                    rd_full_o,
  output logic                    rd_next_full_o
);

  localparam logic [SER_W-1:0] SER_LAST = SER_W'(NO_FEATURE_PLANES_SER - 1);

  logic [STREAM_WIDTH-1:0] mem_q [2][NO_FEATURE_PLANES_SER];
  bank_state_t             st_q  [2];
  bank_state_t             st_d  [2];
  logic                    wr_ptr_q, wr_ptr_d;
  logic                    rd_ptr_q, rd_ptr_d;
  logic [SER_W-1:0]        wr_idx_q, wr_idx_d;
  logic [SER_W-1:0]        wr_addr_s;

  // A bank being released this cycle may be refilled on the same edge.
  assign wr_ready_o     = (st_q[wr_ptr_q] == BANK_EMPTY) || (st_q[wr_ptr_q] == BANK_FILLING) ||
                          (rd_release_i && (wr_ptr_q == rd_ptr_q));
  assign wr_addr_s      = wr_restart_i ? '0 : wr_idx_q;
  assign wr_idx_o       = wr_idx_q;
  assign rd_data_o      = mem_q[rd_ptr_q][rd_ser_i];
  assign rd_full_o      = (st_q[rd_ptr_q] == BANK_FULL);
  assign rd_next_full_o = (st_q[~rd_ptr_q] == BANK_FULL);

  always_comb begin
    st_d     = st_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    wr_idx_d = wr_idx_q;
    if (rd_release_i && rd_start_i) begin
      st_d[rd_ptr_q]  = BANK_EMPTY;
      st_d[~rd_ptr_q] = BANK_REPLAYING;
      rd_ptr_d        = ~rd_ptr_q;
    end else if (rd_release_i) begin
      st_d[rd_ptr_q] = BANK_EMPTY;
      rd_ptr_d       = ~rd_ptr_q;
    end else if (rd_start_i) begin
      st_d[rd_ptr_q] = BANK_REPLAYING;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    // Write updates come last so a same-edge refill overrides the release.
    if (wr_en_i) begin
      if (wr_restart_i) begin
        st_d[wr_ptr_q] = BANK_FILLING;
        wr_idx_d       = SER_W'(1);
      end else if (wr_idx_q == SER_LAST) begin
        st_d[wr_ptr_q] = BANK_FULL;
        wr_ptr_d       = ~wr_ptr_q;
        wr_idx_d       = '0;
      end else begin
        st_d[wr_ptr_q] = BANK_FILLING;
        wr_idx_d       = wr_idx_q + SER_W'(1);
      end
    end else begin
      wr_idx_d = wr_idx_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q[0]  <= BANK_EMPTY;
      st_q[1]  <= BANK_EMPTY;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      wr_idx_q <= '0;
    end else begin
      st_q     <= st_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      wr_idx_q <= wr_idx_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_ptr_q][wr_addr_s] <= wr_data_i;
    end
  end

endmodule

// File: rtl/feature_upsample.sv
// Nearest-neighbour upsampler: stores one serial word group and replays it
// POOL_SIZE times as a framed feature stream.
module feature_upsample
  import cnn_stream_pkg::*;
#(
  parameter int FEATURE_WIDTH         = FEATURE_WIDTH_DEF,
  parameter int NO_FEATURE_PLANES_PAR = NO_FEATURE_PLANES_PAR_DEF,
  parameter int NO_FEATURE_PLANES_SER = NO_FEATURE_PLANES_SER_DEF,
  parameter int POOL_SIZE             = POOL_SIZE_DEF,
  parameter int STREAM_WIDTH          = stream_width(FEATURE_WIDTH, NO_FEATURE_PLANES_PAR)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [STREAM_WIDTH-1:0] in_stream,
  input  logic                    in_valid,
  input  logic                    in_first,
  output logic                    in_ready,
  output logic [STREAM_WIDTH-1:0] feature_stream,
  output logic                    feature_valid,
  output logic                    feature_first,
  output logic                    feature_last,
  output logic                    align_err
);

  localparam int SER_W  = $clog2(NO_FEATURE_PLANES_SER);
  localparam int POOL_W = $clog2(POOL_SIZE);
  localparam logic [SER_W-1:0]  SER_LAST  = SER_W'(NO_FEATURE_PLANES_SER - 1);
  localparam logic [POOL_W-1:0] POOL_LAST = POOL_W'(POOL_SIZE - 1);

  logic                    ready_en_q;
  logic                    active_q, active_d;
  logic [SER_W-1:0]        ser_q, ser_d;
  logic [POOL_W-1:0]       pass_q, pass_d;
  logic [STREAM_WIDTH-1:0] stream_q, stream_d;
  logic                    valid_q, valid_d;
  logic                    first_q, first_d;
  logic                    last_q, last_d;
  logic                    align_q;

  logic                    buf_wr_ready_s;
  logic [SER_W-1:0]        wr_idx_s;
  logic [STREAM_WIDTH-1:0] rd_data_s;
  logic                    rd_full_s, rd_next_full_s;
  logic                    accept_s, misalign_s, last_word_s, rd_start_s;

  assign in_ready    = ready_en_q & buf_wr_ready_s;
  assign accept_s    = in_valid & in_ready;
  assign misalign_s  = accept_s & in_first & (wr_idx_s != '0);
  assign last_word_s = active_q && (ser_q == SER_LAST) && (pass_q == POOL_LAST);
  // Start from idle, or chain straight into the other bank to avoid a bubble.
  assign rd_start_s  = (~active_q & rd_full_s) | (last_word_s & rd_next_full_s);

  feature_pingpong_buf #(
    .STREAM_WIDTH          (STREAM_WIDTH),
    .NO_FEATURE_PLANES_SER (NO_FEATURE_PLANES_SER)
  ) u_buf (
    .clk            (clk),
    .rst_n          (rst_n),
    .wr_en_i        (accept_s),
    .wr_restart_i   (misalign_s),
    .wr_data_i      (in_stream),
    .wr_ready_o     (buf_wr_ready_s),
    .wr_idx_o       (wr_idx_s),
    .rd_start_i     (rd_start_s),
    .rd_release_i   (last_word_s),
    .rd_ser_i       (ser_q),
    .rd_data_o      (rd_data_s),
    .rd_full_o      (rd_full_s),
    .rd_next_full_o (rd_next_full_s)
  );

  always_comb begin
    active_d = active_q;
    ser_d    = ser_q;
    pass_d   = pass_q;
    stream_d = stream_q;
    valid_d  = 1'b0;
    first_d  = 1'b0;
    last_d   = 1'b0;
    if (active_q) begin
      stream_d = rd_data_s;
      valid_d  = 1'b1;
      first_d  = (ser_q == '0) && (pass_q == '0);
      last_d   = last_word_s;
      if (ser_q == SER_LAST) begin
        ser_d = '0;
        if (pass_q == POOL_LAST) begin
          pass_d   = '0;
          active_d = rd_next_full_s;
        end else begin
          pass_d = pass_q + POOL_W'(1);
        end
      end else begin
        ser_d = ser_q + SER_W'(1);
      end
    end else begin
      active_d = rd_full_s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en_q <= 1'b0;
      active_q   <= 1'b0;
      ser_q      <= '0;
      pass_q     <= '0;
      stream_q   <= '0;
      valid_q    <= 1'b0;
      first_q    <= 1'b0;
      last_q     <= 1'b0;
      align_q    <= 1'b0;
    end else begin
      ready_en_q <= 1'b1;
      active_q   <= active_d;
      ser_q      <= ser_d;
      pass_q     <= pass_d;
      stream_q   <= stream_d;
      valid_q    <= valid_d;
      first_q    <= first_d;
      last_q     <= last_d;
      align_q    <= misalign_s;
    end
  end

  assign feature_stream = stream_q;
  assign feature_valid  = valid_q;
  assign feature_first  = first_q;
  assign feature_last   = last_q;
  assign align_err      = align_q;

endmodule
